// File: rtl/serial_subtractor_if.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor_if
// Description : start/done handshake and operand/result bundle of the bit-serial subtractor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);

    localparam int              c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic             r_br;
    logic [c_cw-1:0]  r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_a0       = r_a_sh[0];
    assign w_b0       = r_b_sh[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_br;
    assign w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_res_next = {w_d, r_res_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (bus.start) w_next = c_run;
            c_run:   if (r_cnt == c_last) w_next = c_done;
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                c_run: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= w_res_next[WIDTH-1:1];
                    r_br     <= w_br_next;
                    if (r_cnt == c_last) begin
                        // Result MSB is the bit being produced on this edge.
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != c_idle);
    assign bus.done       = (r_state == c_done);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;
    assign bus.overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_subtractor
// Description : Directed and sweep checks of serial_subtractor with WIDTH = 8.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) u_if ();

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where busy has dropped.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        int bcnt;
        int dcnt;
        bit seen;
        u_if.start = 1'b1;
        u_if.a     = av;
        u_if.b     = bv;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.a     = 8'($urandom);
        u_if.b     = 8'($urandom);
        lat  = 0;
        bcnt = 0;
        dcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (u_if.busy) bcnt++;
            if (u_if.done) begin
                seen = 1'b1;
                dcnt++;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'd8);
        chk("diff", 32'(u_if.diff), 32'(ed));
        chk("borrow_out", 32'(u_if.borrow_out), 32'(eb));
        chk("overflow", 32'(u_if.overflow), 32'(eo));
        @(negedge clk);
        if (u_if.busy) bcnt++;
        if (u_if.done) dcnt++;
        chk("busy_len", 32'(bcnt), 32'd9);
        chk("done_once", 32'(dcnt), 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rd;
        bit         seen;

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        u_if.start = 1'b0;
        u_if.a     = '0;
        u_if.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_done", 32'(u_if.done), 32'd0);
        chk("rst_diff", 32'(u_if.diff), 32'd0);
        chk("rst_borrow", 32'(u_if.borrow_out), 32'd0);
        chk("rst_ovf", 32'(u_if.overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // start held high through RUN and DONE must not disturb the op in flight
        u_if.start = 1'b1;
        u_if.a     = 8'h35;
        u_if.b     = 8'h12;
        @(negedge clk);
        u_if.a = 8'hFF;
        u_if.b = 8'hFF;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i == 4) chk("hold_prev", 32'(u_if.diff), 32'h7F);
            if (u_if.done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("swb_done1", 32'(seen), 32'd1);
        chk("swb_diff1", 32'(u_if.diff), 32'h23);
        @(negedge clk);
        chk("swb_idle", 32'(u_if.busy), 32'd0);
        @(negedge clk);
        chk("swb_accept", 32'(u_if.busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (u_if.done) seen = 1'b1;
            else begin
                chk("swb_hold", 32'(u_if.diff), 32'h23);
                @(negedge clk);
            end
        end
        chk("swb_done2", 32'(seen), 32'd1);
        chk("swb_diff2", 32'(u_if.diff), 32'h00);
        chk("swb_borrow2", 32'(u_if.borrow_out), 32'd0);
        u_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("swb_end", 32'(u_if.busy), 32'd0);

        // reset on the 4th RUN edge aborts the operation
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        u_if.start = 1'b1;
        u_if.a     = 8'h55;
        u_if.b     = 8'h0F;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", 32'(u_if.busy), 32'd0);
        chk("mid_done", 32'(u_if.done), 32'd0);
        chk("mid_diff", 32'(u_if.diff), 32'd0);
        chk("mid_ovf", 32'(u_if.overflow), 32'd0);
        run_op(8'hA0, 8'h0F, 8'h91, 1'b0, 1'b0);

        // reset and start together: reset wins
        rst        = 1'b1;
        u_if.start = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        u_if.start = 1'b0;
        chk("rst_start_busy", 32'(u_if.busy), 32'd0);
        @(negedge clk);
        chk("rst_start_idle", 32'(u_if.busy), 32'd0);

        for (int n = 0; n < 500; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            run_op(ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
